dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of data storage.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to RSP_VALID assertion; legal range 1..7.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 REQ_VALID  input  1  initiator presents a load/store request.
REQ-006 REQ_READY  output  1  responder can accept a request this cycle.
REQ-007 REQ_WE  input  1  1 = store, 0 = load.
REQ-008 REQ_ADDR  input  32  byte address.
REQ-009 REQ_FUNCT3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 REQ_WDATA  input  32  store data, right-aligned.
REQ-011 RSP_VALID  output  1  response available.
REQ-012 RSP_READY  input  1  initiator consumes the response.
REQ-013 RSP_RDATA  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 RSP_ERR  output  1  request was misaligned, out of range or had an illegal funct3.

Function
REQ-015 A request SHALL be accepted when REQ_VALID and REQ_READY are both high on a posedge; all REQ_* fields are captured on that edge.
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP; REQ_READY is high only in IDLE, so at most one request is outstanding.
REQ-017 On accept, the FSM SHALL move IDLE->WAIT and load a 3-bit counter with LATENCY-1; when LATENCY=1, IDLE->RESP directly.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 the FSM moves to RESP, so RSP_VALID rises exactly LATENCY cycles after the accept edge.
REQ-019 In RESP, RSP_VALID, RSP_RDATA and RSP_ERR SHALL hold stable until RSP_READY is high; that edge returns the FSM to IDLE.
REQ-020 A new request SHALL NOT be accepted on the same edge that a response is consumed; REQ_READY rises one cycle after the response is consumed.
REQ-021 A store SHALL write memory on the accept edge, using byte enables derived from funct3 and ADDR[1:0]; unenabled bytes remain unchanged.
REQ-022 A load SHALL read at accept and register the result; B/H loads sign-extend and BU/HU loads zero-extend the addressed lane.
REQ-023 A request whose halfword address is not 2-aligned or whose word address is not 4-aligned SHALL set RSP_ERR=1 and SHALL NOT write memory.
REQ-024 A request with ADDR[31:2] >= DEPTH_WORDS or an illegal funct3 SHALL set RSP_ERR=1 and SHALL NOT write memory; it still takes the full latency.
REQ-025 A load from an address written by the previous accepted store SHALL return the new data.

Reset
REQ-026 While RST is high: the FSM SHALL be in IDLE, the counter 0, REQ_READY=0, RSP_VALID=0, RSP_RDATA=0 and RSP_ERR=0; REQ_READY goes high the first cycle after RST falls.
REQ-027 RST asserted mid-transaction SHALL drop any pending response without emitting it; memory contents are not cleared, and a store already accepted persists.

Configuration
REQ-028 Macro DMEM_MMIO_EN defined: add the output port MMIO_OUT (32 bits, reset 0). A word store to 0x0000_8000 updates MMIO_OUT instead of memory, and a word load from that address returns MMIO_OUT; non-word access there sets RSP_ERR.
REQ-029 Macro DMEM_MMIO_EN undefined: the MMIO_OUT port is absent and address 0x0000_8000 follows REQ-024.

Structure
REQ-030 Shared package mem_pkg SHALL hold the funct3 width enum, the FSM state enum, and the MMIO address constant.
REQ-031 Sub-module dmem_lane_align SHALL be combinational and produce byte enables, the shifted store data and the extended load data from funct3, ADDR[1:0] and the raw word.

Verification
REQ-032 LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> RSP_RDATA=0xDEADBEEF with RSP_ERR=0; each RSP_VALID is first seen 2 cycles after its accept.
REQ-033 After REQ-032: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF.
REQ-034 LW 0x12 and SH 0x11 -> RSP_ERR=1 with RSP_RDATA=0, and a following LW 0x10 shows memory unchanged.
REQ-035 Backpressure: hold RSP_READY=0 for 5 cycles -> RSP_VALID and the data stay stable and REQ_READY=0 throughout; REQ_READY returns 1 cycle after consume.
REQ-036 Assert RST in WAIT -> RSP_VALID never rises for that request, and REQ_READY=1 the first cycle after RST falls.
REQ-037 DMEM_MMIO_EN defined: SW 0x00000005 to 0x8000 -> MMIO_OUT=5 the next cycle, and LW 0x8000 returns 5; with the macro undefined the same SW returns RSP_ERR=1.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] MMIO_ADDR = 32'h0000_8000;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between initiator and responder.
interface dmem_responder_if;

  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_FUNCT3, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_FUNCT3, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering: store byte enables and data,
// load lane extraction with sign/zero extension, alignment and funct3 legality.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_sh_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [31:0] rshift;

  assign rshift = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    wdata_sh_o   = '0;
    rdata_ext_o  = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_sh_o  = {4{wdata_i[7:0]}};
        rdata_ext_o = (funct3_i == F3_B) ? {{24{rshift[7]}}, rshift[7:0]}
                                         : {24'h0, rshift[7:0]};
      end
      F3_H, F3_HU: begin
        misaligned_o = addr_lo_i[0];
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_sh_o   = {2{wdata_i[15:0]}};
        rdata_ext_o  = (funct3_i == F3_H) ? {{16{rshift[15]}}, rshift[15:0]}
                                          : {16'h0, rshift[15:0]};
      end
      F3_W: begin
        misaligned_o = |addr_lo_i;
        be_o         = 4'b1111;
        wdata_sh_o   = wdata_i;
        rdata_ext_o  = rword_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with fixed response latency.
// Optional DMEM_MMIO_EN adds a word-wide MMIO_OUT register at MMIO_ADDR.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  dmem_responder_if.slave   bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0]       MMIO_OUT
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic [31:0]   pend_rdata_q;
  logic          pend_err_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          misaligned;
  logic          illegal;
  logic          in_range;
  logic          accept;
  logic          req_err;
  logic          mem_ok;
  logic          mem_we;
  logic [31:0]   load_word;
  logic [31:0]   rsp_word;

  assign widx     = bus.REQ_ADDR[AW+1:2];
  assign rword    = mem_q[widx];
  assign in_range = ({2'b00, bus.REQ_ADDR[31:2]} < 32'(DEPTH_WORDS));
  assign accept   = bus.REQ_VALID & req_ready_q;

  dmem_lane_align u_lane_align (
    .funct3_i     (bus.REQ_FUNCT3),
    .addr_lo_i    (bus.REQ_ADDR[1:0]),
    .wdata_i      (bus.REQ_WDATA),
    .rword_i      (rword),
    .be_o         (be),
    .wdata_sh_o   (wdata_sh),
    .rdata_ext_o  (rdata_ext),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

`ifdef DMEM_MMIO_EN
  logic        is_mmio;
  logic        mmio_we;
  logic [31:0] mmio_q;

  assign is_mmio  = (bus.REQ_ADDR == MMIO_ADDR);
  assign MMIO_OUT = mmio_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mmio_q <= '0;
    end else if (mmio_we) begin
      mmio_q <= bus.REQ_WDATA;
    end
  end
`endif

  always_comb begin
    req_err   = illegal | misaligned | ~in_range;
    mem_ok    = ~req_err;
    load_word = rdata_ext;
`ifdef DMEM_MMIO_EN
    mmio_we   = 1'b0;
    // The MMIO word shadows any memory location that might alias it.
    if (is_mmio) begin
      req_err   = (bus.REQ_FUNCT3 != F3_W);
      mem_ok    = 1'b0;
      load_word = mmio_q;
      mmio_we   = accept & bus.REQ_WE & ~req_err;
    end
`endif
    rsp_word = (bus.REQ_WE | req_err) ? '0 : load_word;
  end

  assign mem_we = accept & bus.REQ_WE & mem_ok & ~RST;

  // Storage is deliberately not reset: contents survive RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            pend_rdata_q <= rsp_word;
            pend_err_q   <= req_err;
            if (LATENCY == 1) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_word;
              rsp_err_q   <= req_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 3'(LATENCY - 1);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pend_rdata_q;
            rsp_err_q   <= pend_err_q;
          end
        end
        ST_RESP: begin
          // Ready stays low here; IDLE raises it one cycle after the consume.
          if (bus.RSP_READY) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  dmem_responder_if bus ();

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out;
`endif

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef DMEM_MMIO_EN
    ,
    .MMIO_OUT (mmio_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata);
    int n;
    bus.REQ_VALID  = 1'b1;
    bus.REQ_WE     = we;
    bus.REQ_ADDR   = addr;
    bus.REQ_FUNCT3 = f3;
    bus.REQ_WDATA  = wdata;
    n = 0;
    while (!bus.REQ_READY && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_eq("req_ready_timeout", 32'(bus.REQ_READY), 32'd1);
    step();
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic await_rsp(output logic [31:0] rdata, output logic err, output int lat);
    lat = 1;
    while (!bus.RSP_VALID && lat < 20) begin
      step();
      lat++;
    end
    rdata = bus.RSP_RDATA;
    err   = bus.RSP_ERR;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    issue(we, addr, f3, wdata);
    await_rsp(rdata, err, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
    check_eq({tag, "_data"}, rdata, exp_data);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    step();
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;

    n_checks       = 0;
    n_fails        = 0;
    rst            = 1'b1;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'b0;
    bus.REQ_ADDR   = '0;
    bus.REQ_FUNCT3 = 3'b010;
    bus.REQ_WDATA  = '0;
    bus.RSP_READY  = 1'b1;

    repeat (3) step();
    check_eq("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check_eq("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    check_eq("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
`ifdef DMEM_MMIO_EN
    check_eq("rst_mmio_out", mmio_out, 32'h0);
`endif
    rst = 1'b0;
    step();
    check_eq("post_rst_ready", 32'(bus.REQ_READY), 32'd1);

    do_req("sw_10",   1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
    do_req("lw_10",   1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
    do_req("lb_13",   1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0);
    do_req("lbu_13",  1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0);
    do_req("lh_10",   1'b0, 32'h10, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0);
    do_req("sb_11",   1'b1, 32'h11, 3'b000, 32'h00000055, 32'h0,        1'b0);
    do_req("lw_10b",  1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0);
    do_req("lw_12",   1'b0, 32'h12, 3'b010, 32'h0,        32'h0,        1'b1);
    do_req("sh_11",   1'b1, 32'h11, 3'b001, 32'h0000FFFF, 32'h0,        1'b1);
    do_req("lw_10c",  1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0);
    do_req("sw_oor",  1'b1, 32'h1010, 3'b010, 32'hFFFFFFFF, 32'h0,      1'b1);
    do_req("lw_10d",  1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0);
    do_req("f3_ill",  1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1);
    do_req("sw_top",  1'b1, 32'hFFC, 3'b010, 32'h12345678, 32'h0,       1'b0);
    do_req("lb_fff",  1'b0, 32'hFFF, 3'b000, 32'h0,       32'h00000012, 1'b0);
    do_req("sh_12",   1'b1, 32'h12, 3'b001, 32'h0000ABCD, 32'h0,        1'b0);
    do_req("lhu_12",  1'b0, 32'h12, 3'b101, 32'h0,        32'h0000ABCD, 1'b0);

    bus.RSP_READY = 1'b0;
    issue(1'b0, 32'h10, 3'b010, 32'h0);
    await_rsp(rdata, err, lat);
    check_eq("bp_lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", 32'(bus.RSP_VALID), 32'd1);
      check_eq("bp_data", bus.RSP_RDATA, 32'hABCD55EF);
      check_eq("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
    end
    bus.RSP_READY = 1'b1;
    step();
    check_eq("bp_consumed_valid", 32'(bus.RSP_VALID), 32'd0);
    check_eq("bp_consume_ready", 32'(bus.REQ_READY), 32'd0);
    step();
    check_eq("bp_ready_back", 32'(bus.REQ_READY), 32'd1);

    issue(1'b1, 32'h20, 3'b010, 32'hCAFEF00D);
    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", 32'(bus.RSP_VALID), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.REQ_READY), 32'd0);
    rst = 1'b0;
    step();
    check_eq("mid_rst_ready_back", 32'(bus.REQ_READY), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      step();
    end
    do_req("lw_20",   1'b0, 32'h20, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0);
    do_req("lw_10e",  1'b0, 32'h10, 3'b010, 32'h0,        32'hABCD55EF, 1'b0);

`ifdef DMEM_MMIO_EN
    issue(1'b1, 32'h8000, 3'b010, 32'h00000005);
    check_eq("mmio_out", mmio_out, 32'h5);
    await_rsp(rdata, err, lat);
    check_eq("mmio_sw_err", 32'(err), 32'd0);
    step();
    do_req("mmio_lw", 1'b0, 32'h8000, 3'b010, 32'h0,      32'h00000005, 1'b0);
    do_req("mmio_sh", 1'b1, 32'h8000, 3'b001, 32'h0,      32'h0,        1'b1);
    check_eq("mmio_out_kept", mmio_out, 32'h5);
`else
    do_req("mmio_off", 1'b1, 32'h8000, 3'b010, 32'h5,     32'h0,        1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
